// File: rtl/xbar_rsp_arbiter_if.sv
// Bank-to-channel response bus for xbar_rsp_arbiter.
//   bank_rsp_*  : one response source per cache bank (valid/ready handshake)
//   ch_rsp_*    : one registered response slot per upstream channel
// Modports: master = the side that drives bank responses and consumes channel
// responses; slave = the arbiter itself.
interface xbar_rsp_arbiter_if #(
    parameter int NUM_BANKS    = 4,
    parameter int NUM_CHANNELS = 3,
    parameter int DATA_W       = 128,
    parameter int ROB_W        = 8
);
    logic [NUM_BANKS-1:0]                 bank_rsp_valid;
    logic [NUM_BANKS-1:0]                 bank_rsp_ready;
    logic [NUM_BANKS-1:0][DATA_W-1:0]     bank_rsp_data;
    logic [NUM_BANKS-1:0][ROB_W-1:0]      bank_rsp_rob_id;
    logic [NUM_BANKS-1:0][1:0]            bank_rsp_channel_id;

    logic [NUM_CHANNELS-1:0]              ch_rsp_valid;
    logic [NUM_CHANNELS-1:0]              ch_rsp_ready;
    logic [NUM_CHANNELS-1:0][DATA_W-1:0]  ch_rsp_data;
    logic [NUM_CHANNELS-1:0][ROB_W-1:0]   ch_rsp_rob_id;
    logic [NUM_CHANNELS-1:0][1:0]         ch_rsp_bank_id;

    modport master (
        output bank_rsp_valid, bank_rsp_data, bank_rsp_rob_id, bank_rsp_channel_id,
        input  bank_rsp_ready,
        input  ch_rsp_valid, ch_rsp_data, ch_rsp_rob_id, ch_rsp_bank_id,
        output ch_rsp_ready
    );

    modport slave (
        input  bank_rsp_valid, bank_rsp_data, bank_rsp_rob_id, bank_rsp_channel_id,
        output bank_rsp_ready,
        output ch_rsp_valid, ch_rsp_data, ch_rsp_rob_id, ch_rsp_bank_id,
        input  ch_rsp_ready
    );
endinterface

// File: rtl/xbar_rsp_arbiter.sv
// Response-side scheduler of the crossbar. Bank read completions are routed to
// the upstream channel named by their channel_id; each channel owns a
// round-robin arbiter and a one-entry output slot with full-throughput
// valid/ready. Responses carrying an illegal channel id are accepted and
// dropped, flagged in err_bad_channel and counted in drop_cnt.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : bank_rsp_* inputs / bank_rsp_ready, ch_rsp_* slots
//   err_bad_channel  : sticky illegal-channel flag
//   drop_cnt         : saturating count of dropped responses

// One channel: round-robin grant over the banks requesting it, plus its slot.
module xbar_rsp_channel #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 128,
    parameter int ROB_W     = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_BANKS-1:0]             req,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0] bank_data,
    input  logic [NUM_BANKS-1:0][ROB_W-1:0]  bank_rob,
    input  logic                             rsp_ready,
    output logic [NUM_BANKS-1:0]             accept,
    output logic                             rsp_valid,
    output logic [DATA_W-1:0]                rsp_data,
    output logic [ROB_W-1:0]                 rsp_rob,
    output logic [1:0]                       rsp_bank
);
    logic [1:0] rr_ptr;
    logic [1:0] gnt_idx;
    logic [1:0] idx;
    logic       gnt_any;
    logic       load;

    // First requester at or after rr_ptr, wrapping modulo NUM_BANKS.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            idx = 2'((int'(rr_ptr) + i) % NUM_BANKS);
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // Slot may load when empty or draining this cycle.
    assign load = gnt_any & (~rsp_valid | rsp_ready);

    always_comb begin
        accept = '0;
        if (load) accept[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rob   <= '0;
            rsp_bank  <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= bank_data[gnt_idx];
            rsp_rob   <= bank_rob[gnt_idx];
            rsp_bank  <= gnt_idx;
            rr_ptr    <= (int'(gnt_idx) == NUM_BANKS - 1) ? 2'd0 : gnt_idx + 2'd1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

module xbar_rsp_arbiter #(
    parameter int NUM_BANKS    = 4,
    parameter int NUM_CHANNELS = 3,
    parameter int DATA_W       = 128,
    parameter int ROB_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xbar_rsp_arbiter_if.slave    bus,
    output logic                 err_bad_channel,
    output logic [15:0]          drop_cnt
);
    localparam int CNT_W = $clog2(NUM_BANKS + 1);

    logic [NUM_CHANNELS-1:0][NUM_BANKS-1:0] req;
    logic [NUM_CHANNELS-1:0][NUM_BANKS-1:0] acc;
    logic [NUM_BANKS-1:0]                   bad;
    logic [NUM_BANKS-1:0]                   bank_ready;
    logic [CNT_W-1:0]                       bad_cnt;
    logic [16:0]                            drop_sum;

    always_comb begin
        req = '0;
        bad = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bad[b] = bus.bank_rsp_valid[b] & (int'(bus.bank_rsp_channel_id[b]) >= NUM_CHANNELS);
            for (int c = 0; c < NUM_CHANNELS; c++)
                req[c][b] = bus.bank_rsp_valid[b] & (int'(bus.bank_rsp_channel_id[b]) == c);
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        xbar_rsp_channel #(
            .NUM_BANKS (NUM_BANKS),
            .DATA_W    (DATA_W),
            .ROB_W     (ROB_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req[c]),
            .bank_data (bus.bank_rsp_data),
            .bank_rob  (bus.bank_rsp_rob_id),
            .rsp_ready (bus.ch_rsp_ready[c]),
            .accept    (acc[c]),
            .rsp_valid (bus.ch_rsp_valid[c]),
            .rsp_data  (bus.ch_rsp_data[c]),
            .rsp_rob   (bus.ch_rsp_rob_id[c]),
            .rsp_bank  (bus.ch_rsp_bank_id[c])
        );
    end

    // Illegal-id responses are always taken so they cannot wedge the bank.
    // Ready is forced low during reset since it is purely combinational.
    always_comb begin
        bank_ready = bad;
        for (int c = 0; c < NUM_CHANNELS; c++) bank_ready |= acc[c];
        bus.bank_rsp_ready = rst_n ? bank_ready : '0;
    end

    always_comb begin
        bad_cnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) bad_cnt += CNT_W'(bad[b]);
        drop_sum = {1'b0, drop_cnt} + 17'(bad_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_bad_channel <= 1'b0;
            drop_cnt        <= '0;
        end else if (|bad) begin
            err_bad_channel <= 1'b1;
            drop_cnt        <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule
